// File: rtl/pam4_edge_gen_pkg.sv
// pam4_edge_gen_pkg: shared definitions for the PAM4 edge generator.
//   - channel bit positions (R=2, G=1, B=0)
//   - FSM state encoding
//   - PAM4 level type and the level-to-pulse-width lookup
package pam4_edge_gen_pkg;

    localparam int CH_R   = 2;
    localparam int CH_G   = 1;
    localparam int CH_B   = 0;
    localparam int NUM_CH = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [1:0] pam4_level_t;

    // High-time in ticks for one PAM4 level.
    function automatic logic [3:0] level_width(
        input pam4_level_t lvl,
        input logic [3:0]  w0,
        input logic [3:0]  w1,
        input logic [3:0]  w2,
        input logic [3:0]  w3
    );
        case (lvl)
            2'd0:    return w0;
            2'd1:    return w1;
            2'd2:    return w2;
            default: return w3;
        endcase
    endfunction

endpackage

// File: rtl/pam4_edge_gen_if.sv
// pam4_edge_gen_if: symbol valid/ready handshake carrying one PAM4 level
// per colour channel.
//   sym_valid  upstream symbol available
//   sym_ready  block accepts symbol this cycle
//   sym_r/g/b  PAM4 levels for red/green/blue
interface pam4_edge_gen_if;
    import pam4_edge_gen_pkg::*;

    logic        sym_valid;
    logic        sym_ready;
    pam4_level_t sym_r;
    pam4_level_t sym_g;
    pam4_level_t sym_b;

    modport master (output sym_valid, sym_r, sym_g, sym_b, input sym_ready);
    modport slave  (input sym_valid, sym_r, sym_g, sym_b, output sym_ready);

endinterface

// File: rtl/pam4_edge_gen_chan.sv
// pam4_chan_edge: per-channel edge decoder.
//   clk_x10, g_rst  fast clock, synchronous active-high reset
//   phase_i         tick position within the current symbol
//   run_i           FSM is in RUN
//   flush_i         first IDLE cycle after an underflow
//   level_i         PAM4 level of the current symbol
//   rising_o        one-cycle rise pulse
//   falling_o       one-cycle fall pulse
//   line_state_o    registered logical line level
module pam4_chan_edge
    import pam4_edge_gen_pkg::*;
#(
    parameter int PERIOD = 10,
    parameter int W0     = 0,
    parameter int W1     = 3,
    parameter int W2     = 6,
    parameter int W3     = 10
) (
    input  logic        clk_x10,
    input  logic        g_rst,
    input  logic [3:0]  phase_i,
    input  logic        run_i,
    input  logic        flush_i,
    input  pam4_level_t level_i,
    output logic        rising_o,
    output logic        falling_o,
    output logic        line_state_o
);

    localparam logic [3:0] PERIOD_4 = 4'(PERIOD);
    localparam logic [3:0] W0_4     = 4'(W0);
    localparam logic [3:0] W1_4     = 4'(W1);
    localparam logic [3:0] W2_4     = 4'(W2);
    localparam logic [3:0] W3_4     = 4'(W3);

    logic       line_q;
    logic       line_d;
    logic [3:0] width;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        width     = level_width(level_i, W0_4, W1_4, W2_4, W3_4);
        // A line that is already high (full-width predecessor) gets no new rise.
        rising_o  = run_i & (phase_i == 4'd0) & (width != 4'd0) & ~line_q;
        // Full-width symbols never fall mid-symbol; a width of 0 falls at phase 0.
        // The flush term closes a pulse left open by a full-width last symbol.
        falling_o = (run_i & line_q & (width < PERIOD_4) & (phase_i == width))
                  | (flush_i & line_q);
        line_d    = line_q;
        if (rising_o) begin
            line_d = 1'b1;
        end else if (falling_o) begin
            line_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_x10) begin
        if (g_rst) begin
            line_q <= 1'b0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_state_o = line_q;

endmodule

// File: rtl/pam4_edge_gen.sv
// pam4_edge_gen: turns one PAM4 level per colour channel per symbol into
// single-cycle rise/fall pulses; the level is the pulse width inside a
// PERIOD-tick window on clk_x10.
//   clk_x10, g_rst   fast clock, synchronous active-high reset
//   sym_if           slave side of the symbol valid/ready handshake
//   rising_edge_o    one-cycle rise pulses, bit2=R bit1=G bit0=B
//   falling_edge_o   one-cycle fall pulses, same bit order
//   line_state_o     registered logical level per channel
//   busy_o           high while a symbol is being played out
//   underflow_cnt_o  saturating count of stream underflows
module pam4_edge_gen
    import pam4_edge_gen_pkg::*;
#(
    parameter int PERIOD = 10,
    parameter int W0     = 0,
    parameter int W1     = 3,
    parameter int W2     = 6,
    parameter int W3     = 10
) (
    input  logic                  clk_x10,
    input  logic                  g_rst,
    pam4_edge_gen_if.slave        sym_if,
    output logic [NUM_CH-1:0]     rising_edge_o,
    output logic [NUM_CH-1:0]     falling_edge_o,
    output logic [NUM_CH-1:0]     line_state_o,
    output logic                  busy_o,
    output logic [7:0]            underflow_cnt_o
);

    localparam logic [3:0] LAST_PHASE = 4'(PERIOD - 1);

    state_e                   state_q, state_d;
    logic [3:0]               phase_q, phase_d;
    pam4_level_t [NUM_CH-1:0] level_q, level_d;
    logic                     flush_q, flush_d;
    logic [7:0]               ucnt_q, ucnt_d;

    logic sym_end;
    logic accept;

    assign sym_end          = (state_q == RUN) && (phase_q == LAST_PHASE);
    assign sym_if.sym_ready = (state_q == IDLE) || sym_end;
    assign accept           = sym_if.sym_valid && sym_if.sym_ready;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        level_d = level_q;
        ucnt_d  = ucnt_q;
        flush_d = 1'b0;
        if (accept) begin
            // Accepting at the last phase restarts at 0 with no gap cycle.
            level_d[CH_R] = sym_if.sym_r;
            level_d[CH_G] = sym_if.sym_g;
            level_d[CH_B] = sym_if.sym_b;
            phase_d       = 4'd0;
            state_d       = RUN;
        end else if (state_q == RUN) begin
            if (sym_end) begin
                state_d = IDLE;
                phase_d = 4'd0;
                flush_d = 1'b1;
                ucnt_d  = (ucnt_q == 8'hFF) ? ucnt_q : ucnt_q + 8'd1;
            end else begin
                phase_d = phase_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_x10) begin
        if (g_rst) begin
            state_q <= IDLE;
            phase_q <= 4'd0;
            level_q <= '0;
            flush_q <= 1'b0;
            ucnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            level_q <= level_d;
            flush_q <= flush_d;
            ucnt_q  <= ucnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        pam4_chan_edge #(
            .PERIOD (PERIOD),
            .W0     (W0),
            .W1     (W1),
            .W2     (W2),
            .W3     (W3)
        ) u_chan (
            .clk_x10      (clk_x10),
            .g_rst        (g_rst),
            .phase_i      (phase_q),
            .run_i        (state_q == RUN),
            .flush_i      (flush_q),
            .level_i      (level_q[i]),
            .rising_o     (rising_edge_o[i]),
            .falling_o    (falling_edge_o[i]),
            .line_state_o (line_state_o[i])
        );
    end

    assign busy_o          = (state_q == RUN);
    assign underflow_cnt_o = ucnt_q;

endmodule

// File: tb/tb_pam4_edge_gen.sv
// tb_pam4_edge_gen: directed bench for pam4_edge_gen. Expected edge events
// are queued with their absolute cycle when a symbol is driven; a negedge
// monitor pops them and compares every cycle (no event queued = no edge).
module tb_pam4_edge_gen;
    import pam4_edge_gen_pkg::*;

    logic clk_x10 = 1'b0;
    logic g_rst   = 1'b1;
    always #5 clk_x10 = ~clk_x10;

    pam4_edge_gen_if sym_if ();

    logic [2:0] rising_edge;
    logic [2:0] falling_edge;
    logic [2:0] line_state;
    logic       busy;
    logic [7:0] underflow_cnt;

    pam4_edge_gen #(
        .PERIOD (10), .W0 (0), .W1 (3), .W2 (6), .W3 (10)
    ) dut (
        .clk_x10         (clk_x10),
        .g_rst           (g_rst),
        .sym_if          (sym_if),
        .rising_edge_o   (rising_edge),
        .falling_edge_o  (falling_edge),
        .line_state_o    (line_state),
        .busy_o          (busy),
        .underflow_cnt_o (underflow_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int       cyc;
        logic [2:0] rise;
        logic [2:0] fall;
    } ev_t;

    ev_t sb[$];

    always @(posedge clk_x10) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Merge into an existing entry for the same cycle, else insert in order.
    task automatic push_ev(input int c, input logic [2:0] r, input logic [2:0] f);
        ev_t e;
        e.cyc  = c;
        e.rise = r;
        e.fall = f;
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].cyc == c) begin
                sb[k].rise = sb[k].rise | r;
                sb[k].fall = sb[k].fall | f;
                return;
            end
            if (sb[k].cyc > c) begin
                sb.insert(k, e);
                return;
            end
        end
        sb.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_x10);
            #1;
        end
    endtask

    task automatic drive(input bit v, input pam4_level_t r, input pam4_level_t g, input pam4_level_t b);
        sym_if.sym_valid = v;
        sym_if.sym_r     = r;
        sym_if.sym_g     = g;
        sym_if.sym_b     = b;
    endtask

    logic [2:0] mon_er;
    logic [2:0] mon_ef;

    always @(negedge clk_x10) begin
        if (mon_en) begin
            mon_er = 3'b000;
            mon_ef = 3'b000;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("scoreboard_stale_event_cycle", sb[0].cyc, cyc);
                sb.delete(0);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_er = sb[0].rise;
                mon_ef = sb[0].fall;
                sb.delete(0);
            end
            check("rising_edge", 32'(rising_edge), 32'(mon_er));
            check("falling_edge", 32'(falling_edge), 32'(mon_ef));
            n_assert++;
            assert ((rising_edge & falling_edge) === 3'b000) else begin
                n_fail++;
                $error("FAIL rise_fall_overlap: observed 0x%0h expected 0x0 (cycle %0d)",
                       rising_edge & falling_edge, cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int t2;

        drive(1'b0, 2'd0, 2'd0, 2'd0);
        g_rst = 1'b1;
        tick(2);
        g_rst  = 1'b0;
        mon_en = 1'b1;

        // Reset state
        check("reset_rising", 32'(rising_edge), 32'h0);
        check("reset_falling", 32'(falling_edge), 32'h0);
        check("reset_ready", 32'(sym_if.sym_ready), 32'h1);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_line", 32'(line_state), 32'h0);
        check("reset_ucnt", 32'(underflow_cnt), 32'h0);

        // Single symbol R=2 G=1 B=3, then underflow with blue flushed
        t = cyc;
        drive(1'b1, 2'd2, 2'd1, 2'd3);
        push_ev(t + 1, 3'b111, 3'b000);
        push_ev(t + 4, 3'b000, 3'b010);
        push_ev(t + 7, 3'b000, 3'b100);
        push_ev(t + 11, 3'b000, 3'b001);
        tick();
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        check("single_busy", 32'(busy), 32'h1);
        check("single_ready_mid", 32'(sym_if.sym_ready), 32'h0);
        tick(10);
        check("single_flush_ucnt", 32'(underflow_cnt), 32'd1);
        check("single_flush_busy", 32'(busy), 32'h0);
        check("single_flush_line", 32'(line_state), 32'b001);
        tick();
        check("single_after_flush_line", 32'(line_state), 32'h0);

        // Back-to-back R=3,3,0: one rise, no boundary edge, fall at symbol 3
        t = cyc;
        drive(1'b1, 2'd3, 2'd0, 2'd0);
        push_ev(t + 1, 3'b100, 3'b000);
        push_ev(t + 21, 3'b000, 3'b100);
        tick();
        check("b2b_ready_phase0", 32'(sym_if.sym_ready), 32'h0);
        tick(9);
        check("b2b_ready_sym1_end", 32'(sym_if.sym_ready), 32'h1);
        tick();
        check("b2b_ready_sym2_start", 32'(sym_if.sym_ready), 32'h0);
        check("b2b_line_sym2", 32'(line_state), 32'b100);
        tick(9);
        check("b2b_ready_sym2_end", 32'(sym_if.sym_ready), 32'h1);
        drive(1'b1, 2'd0, 2'd0, 2'd0);
        tick();
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        check("b2b_line_at_fall", 32'(line_state), 32'b100);
        tick(10);
        check("b2b_ucnt", 32'(underflow_cnt), 32'd2);
        check("b2b_line_end", 32'(line_state), 32'h0);
        check("b2b_busy_end", 32'(busy), 32'h0);

        // All-zero stream: no edges, line stays low
        drive(1'b1, 2'd0, 2'd0, 2'd0);
        tick(15);
        check("zero_line", 32'(line_state), 32'h0);
        check("zero_busy", 32'(busy), 32'h1);
        tick(6);
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        tick(10);
        check("zero_ucnt", 32'(underflow_cnt), 32'd3);
        check("zero_busy_end", 32'(busy), 32'h0);

        // Gap: R=1, valid low through the symbol end and 5 more cycles
        t = cyc;
        drive(1'b1, 2'd1, 2'd0, 2'd0);
        push_ev(t + 1, 3'b100, 3'b000);
        push_ev(t + 4, 3'b000, 3'b100);
        tick();
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        tick(10);
        check("gap_ucnt", 32'(underflow_cnt), 32'd4);
        check("gap_busy", 32'(busy), 32'h0);
        tick(4);
        check("gap_ready_idle", 32'(sym_if.sym_ready), 32'h1);
        t2 = cyc;
        drive(1'b1, 2'd1, 2'd0, 2'd0);
        push_ev(t2 + 1, 3'b100, 3'b000);
        push_ev(t2 + 4, 3'b000, 3'b100);
        tick();
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        check("gap_resume_rise", 32'(rising_edge), 32'b100);
        check("gap_resume_busy", 32'(busy), 32'h1);
        tick(10);
        check("gap_ucnt2", 32'(underflow_cnt), 32'd5);

        // Reset at phase 2 of a G=3 symbol: no flush pulse
        t = cyc;
        drive(1'b1, 2'd0, 2'd3, 2'd0);
        push_ev(t + 1, 3'b010, 3'b000);
        tick();
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        tick(2);
        check("rst_mid_line_before", 32'(line_state), 32'b010);
        g_rst = 1'b1;
        tick();
        check("rst_mid_rising", 32'(rising_edge), 32'h0);
        check("rst_mid_falling", 32'(falling_edge), 32'h0);
        check("rst_mid_line", 32'(line_state), 32'h0);
        check("rst_mid_ready", 32'(sym_if.sym_ready), 32'h1);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_ucnt", 32'(underflow_cnt), 32'h0);
        g_rst = 1'b0;
        tick();

        // Saturation: 255 underflows reach the ceiling, 45 more stay there
        repeat (255) begin
            drive(1'b1, 2'd0, 2'd0, 2'd0);
            tick();
            drive(1'b0, 2'd0, 2'd0, 2'd0);
            tick(10);
        end
        check("sat_ucnt_255", 32'(underflow_cnt), 32'd255);
        repeat (45) begin
            drive(1'b1, 2'd0, 2'd0, 2'd0);
            tick();
            drive(1'b0, 2'd0, 2'd0, 2'd0);
            tick(10);
        end
        check("sat_ucnt_300", 32'(underflow_cnt), 32'd255);

        tick(3);
        check("scoreboard_drained", sb.size(), 32'd0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
